// File: rtl/corner_packer_pkg.sv
// rtl/corner_packer_pkg.sv - shared field offsets, beat magics and FSM encoding for corner_packer
package corner_packer_pkg;

    localparam int COL_LSB = 18;
    localparam int COL_W   = 11;
    localparam int ROW_LSB = 8;
    localparam int ROW_W   = 10;

    localparam logic [31:0] HDR_MAGIC = 32'hC0C0_0001;
    localparam logic [31:0] TRL_MAGIC = 32'hC0C0_00FF;
    // Reserved bits 30:29 set, so a pad can never be mistaken for a corner
    localparam logic [31:0] PAD_WORD  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_TRL   = 3'd4
    } state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {14'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/corner_packer_beat_fifo.sv
// rtl/corner_packer_beat_fifo.sv - show-ahead beat FIFO; a pop frees room for a same-cycle push
module beat_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/corner_packer.sv
// rtl/corner_packer.sv - validates corner words, packs four per beat, frames them with header/trailer
module corner_packer
    import corner_packer_pkg::*;
#(
    parameter logic CAM_ADDR    = 1'b0,
    parameter int   COLS        = 1280,
    parameter int   ROWS        = 1024,
    parameter int   FLUSH_DELAY = 32,
    parameter int   FIFO_DEPTH  = 16
) (
    input  logic         c,
    input  logic         rst,
    input  logic         en,
    input  logic         fv,
    input  logic [31:0]  d,
    input  logic         dv,
    input  logic         rd,
    output logic [127:0] q,
    output logic         qv,
    output logic [15:0]  frame_num,
    output logic [15:0]  corner_cnt,
    output logic [15:0]  drop_cnt,
    output logic         overflow
);
    localparam int IDLE_W = $clog2(FLUSH_DELAY + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FLUSH_DELAY);

    state_t            state_q;
    logic              fv_q, pend_q, overflow_q;
    logic [15:0]       frame_q, corner_q, drop_q;
    logic [1:0]        acc_cnt_q;
    logic [31:0]       acc_q [4];
    logic [IDLE_W-1:0] idle_q;

    logic              push, can_push, fifo_full, fifo_empty, fv_rise, word_ok, beat_lost;
    logic [127:0]      push_data;

    assign fv_rise  = fv && !fv_q;
    assign can_push = !fifo_full || rd;
    assign word_ok  = (d[30:29] == 2'b00) && (d[31] == CAM_ADDR)
                   && ({21'd0, d[COL_LSB +: COL_W]} < 32'(COLS))
                   && ({22'd0, d[ROW_LSB +: ROW_W]} < 32'(ROWS));
    assign beat_lost = (state_q == ST_DATA) && dv && word_ok && (acc_cnt_q == 2'd3) && !can_push;

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        case (state_q)
            ST_HDR: begin
                push      = 1'b1;
                push_data = {32'd0, {31'd0, CAM_ADDR}, {16'd0, frame_q}, HDR_MAGIC};
            end
            ST_DATA: if (dv && word_ok && acc_cnt_q == 2'd3) begin
                push      = 1'b1;
                push_data = {d, acc_q[2], acc_q[1], acc_q[0]};
            end
            ST_FLUSH: if (acc_cnt_q != 2'd0) begin
                push      = 1'b1;
                push_data = {PAD_WORD,
                             (acc_cnt_q == 2'd3) ? acc_q[2] : PAD_WORD,
                             (acc_cnt_q >= 2'd2) ? acc_q[1] : PAD_WORD,
                             acc_q[0]};
            end
            ST_TRL: begin
                push      = 1'b1;
                push_data = {16'd0, drop_q, 16'd0, corner_q, 16'd0, frame_q, TRL_MAGIC};
            end
            default: ;
        endcase
    end

    // fv_q resets high so a frame already in progress at reset release is skipped
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fv_q       <= 1'b1;
            pend_q     <= 1'b0;
            overflow_q <= 1'b0;
            frame_q    <= '0;
            corner_q   <= '0;
            drop_q     <= '0;
            acc_cnt_q  <= '0;
            idle_q     <= '0;
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
        end else begin
            fv_q <= fv;
            case (state_q)
                ST_IDLE: if (fv_rise && en) begin
                    state_q   <= ST_HDR;
                    frame_q   <= frame_q + 16'd1;
                    corner_q  <= '0;
                    drop_q    <= '0;
                    acc_cnt_q <= '0;
                end
                ST_HDR: begin
                    if (dv) drop_q <= sat_add16(drop_q, 3'd1);
                    if (can_push) begin
                        state_q <= ST_DATA;
                        idle_q  <= '0;
                    end
                end
                ST_DATA: begin
                    if (dv && word_ok) begin
                        acc_q[acc_cnt_q] <= d;
                        acc_cnt_q        <= acc_cnt_q + 2'd1;
                        corner_q         <= sat_add16(corner_q, 3'd1);
                        if (beat_lost) begin
                            overflow_q <= 1'b1;
                            drop_q     <= sat_add16(drop_q, 3'd4);
                        end
                    end else if (dv) begin
                        drop_q <= sat_add16(drop_q, 3'd1);
                    end
                    if (dv || fv)              idle_q <= '0;
                    else if (idle_q != IDLE_MAX) idle_q <= idle_q + 1'b1;
                    if (fv_rise) begin
                        pend_q  <= 1'b1;
                        state_q <= ST_FLUSH;
                    end else if (!fv && idle_q == IDLE_MAX) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (dv)      drop_q <= sat_add16(drop_q, 3'd1);
                    if (fv_rise) pend_q <= 1'b1;
                    if (acc_cnt_q == 2'd0) begin
                        state_q <= ST_TRL;
                    end else if (can_push) begin
                        acc_cnt_q <= '0;
                        state_q   <= ST_TRL;
                    end
                end
                ST_TRL: begin
                    if (dv)      drop_q <= sat_add16(drop_q, 3'd1);
                    if (fv_rise) pend_q <= 1'b1;
                    if (can_push) begin
                        pend_q <= 1'b0;
                        if ((pend_q || fv_rise) && en) begin
                            state_q   <= ST_HDR;
                            frame_q   <= frame_q + 16'd1;
                            corner_q  <= '0;
                            drop_q    <= '0;
                            acc_cnt_q <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    beat_fifo #(.W(128), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (c),
        .rst   (rst),
        .push  (push && can_push),
        .pop   (rd),
        .wdata (push_data),
        .rdata (q),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign qv         = !fifo_empty;
    assign frame_num  = frame_q;
    assign corner_cnt = corner_q;
    assign drop_cnt   = drop_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_corner_packer.sv
// tb/tb_corner_packer.sv - self-checking bench for corner_packer against a frame-level beat model
module tb_corner_packer;

    logic         c = 1'b0;
    logic         rst, en, fv, dv, rd;
    logic [31:0]  d;
    logic [127:0] q;
    logic         qv, overflow;
    logic [15:0]  frame_num, corner_cnt, drop_cnt;

    corner_packer dut (
        .c(c), .rst(rst), .en(en), .fv(fv), .d(d), .dv(dv), .rd(rd),
        .q(q), .qv(qv), .frame_num(frame_num), .corner_cnt(corner_cnt),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 c = ~c;

    logic [127:0] got_q[$];
    logic [127:0] exp_q[$];
    logic [31:0]  frame_words[$];
    int n_checks = 0;
    int n_fail   = 0;
    int exp_frame = 0;
    int m_corner, m_drop;

    // Beats are popped on the rising edge after a falling edge that saw rd & qv
    always @(negedge c) if (!rst && rd && qv) got_q.push_back(q);

    task automatic cyc();
        @(posedge c);
        #2;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mkw(input logic cam, input logic [1:0] rs,
                                        input int col, input int row, input logic [7:0] sc);
        return {cam, rs, col[10:0], row[9:0], sc};
    endfunction

    function automatic logic [31:0] rand_valid();
        return mkw(1'b0, 2'b00, int'($urandom_range(0, 1279)), int'($urandom_range(0, 1023)),
                   8'($urandom));
    endfunction

    function automatic bit model_ok(input logic [31:0] w);
        int col, row;
        col = int'(w[28:18]);
        row = int'(w[17:8]);
        return (w[31] == 1'b0) && (w[30:29] == 2'b00) && (col < 1280) && (row < 1024);
    endfunction

    task automatic model_header(input int fn);
        exp_q.push_back({32'd0, 32'd0, 16'd0, 16'(fn), 32'hC0C0_0001});
    endtask

    task automatic model_trailer(input int fn, input int cc, input int dc);
        exp_q.push_back({16'd0, 16'(dc), 16'd0, 16'(cc), 16'd0, 16'(fn), 32'hC0C0_00FF});
    endtask

    task automatic model_data();
        logic [31:0] acc[$];
        m_corner = 0;
        m_drop   = 0;
        foreach (frame_words[i]) begin
            if (model_ok(frame_words[i])) begin
                acc.push_back(frame_words[i]);
                m_corner++;
                if (acc.size() == 4) begin
                    exp_q.push_back({acc[3], acc[2], acc[1], acc[0]});
                    acc.delete();
                end
            end else begin
                m_drop++;
            end
        end
        if (acc.size() > 0) begin
            while (acc.size() < 4) acc.push_back(32'hFFFF_FFFF);
            exp_q.push_back({acc[3], acc[2], acc[1], acc[0]});
        end
    endtask

    task automatic model_frame();
        exp_frame++;
        model_header(exp_frame);
        model_data();
        model_trailer(exp_frame, m_corner, m_drop);
    endtask

    task automatic open_frame();
        fv = 1'b1;
        repeat (4) cyc();
    endtask

    task automatic send_words(input bit gaps);
        foreach (frame_words[i]) begin
            d  = frame_words[i];
            dv = 1'b1;
            cyc();
            dv = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) cyc();
        end
    endtask

    task automatic finish_frame(input string tag);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 500) begin
            cyc();
            t++;
        end
        repeat (4) cyc();
        chk({tag, " beat count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s beat%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [31:0] w;
        bit          ok;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{mkw(1'b0, 2'b00, 1280, 5, 8'h01), 1'b0};
        tbl[1] = '{mkw(1'b0, 2'b00, 2000, 7, 8'h02), 1'b0};
        tbl[2] = '{mkw(1'b1, 2'b00, 5, 5, 8'h03), 1'b0};
        tbl[3] = '{mkw(1'b0, 2'b01, 5, 5, 8'h04), 1'b0};
        tbl[4] = '{mkw(1'b0, 2'b00, 1279, 1023, 8'hFF), 1'b1};
        tbl[5] = '{mkw(1'b0, 2'b00, 0, 0, 8'h00), 1'b1};
        tbl[6] = '{mkw(1'b0, 2'b10, 0, 0, 8'h00), 1'b0};
        tbl[7] = '{mkw(1'b0, 2'b11, 10, 10, 8'h00), 1'b0};
        tbl[8] = '{mkw(1'b0, 2'b00, 640, 512, 8'h07), 1'b1};

        rst = 1'b1; en = 1'b1; fv = 1'b0; dv = 1'b0; rd = 1'b1; d = '0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("reset q", q, 128'd0);
        chk("reset qv", 128'(qv), 128'd0);
        chk("reset frame_num", 128'(frame_num), 128'd0);
        chk("reset corner_cnt", 128'(corner_cnt), 128'd0);
        chk("reset drop_cnt", 128'(drop_cnt), 128'd0);
        chk("reset overflow", 128'(overflow), 128'd0);

        // eight valid words -> two full beats
        frame_words.delete();
        for (int i = 0; i < 8; i++) frame_words.push_back(rand_valid());
        model_frame();
        open_frame(); send_words(1'b0); fv = 1'b0;
        finish_frame("t1");
        chk("t1 corner_cnt", 128'(corner_cnt), 128'd8);

        // five valid words -> second beat padded
        frame_words.delete();
        for (int i = 0; i < 5; i++) frame_words.push_back(rand_valid());
        model_frame();
        open_frame(); send_words(1'b0); fv = 1'b0;
        finish_frame("t2");
        chk("t2 corner_cnt", 128'(corner_cnt), 128'd5);

        // validator boundaries, counters checked word by word
        frame_words.delete();
        foreach (tbl[i]) frame_words.push_back(tbl[i].w);
        model_frame();
        open_frame();
        begin
            int ec = 0, ed = 0;
            foreach (tbl[i]) begin
                d = tbl[i].w; dv = 1'b1; cyc(); dv = 1'b0;
                if (tbl[i].ok) ec++; else ed++;
                chk($sformatf("t3 corner_cnt w%0d", i), 128'(corner_cnt), 128'(ec));
                chk($sformatf("t3 drop_cnt w%0d", i), 128'(drop_cnt), 128'(ed));
            end
        end
        fv = 1'b0;
        finish_frame("t3");

        // overflow: 80 words with no reader, 15 beats fit behind the header
        rd = 1'b0;
        frame_words.delete();
        for (int i = 0; i < 80; i++) frame_words.push_back(rand_valid());
        open_frame(); send_words(1'b0);
        chk("t4 overflow", 128'(overflow), 128'd1);
        chk("t4 qv", 128'(qv), 128'd1);
        chk("t4 corner_cnt", 128'(corner_cnt), 128'd80);
        chk("t4 drop_cnt", 128'(drop_cnt), 128'd20);
        fv = 1'b0;
        repeat (50) cyc();
        exp_frame++;
        model_header(exp_frame);
        frame_words = frame_words[0:59];
        model_data();
        model_trailer(exp_frame, 80, 20);
        rd = 1'b1;
        finish_frame("t4");
        chk("t4 overflow sticky", 128'(overflow), 128'd1);

        // new fv rise while in DATA closes the old frame and opens the next
        frame_words.delete();
        for (int i = 0; i < 3; i++) frame_words.push_back(rand_valid());
        model_frame();
        open_frame(); send_words(1'b0);
        fv = 1'b0; repeat (2) cyc();
        fv = 1'b1; repeat (6) cyc();
        frame_words.delete();
        for (int i = 0; i < 4; i++) frame_words.push_back(rand_valid());
        model_frame();
        send_words(1'b0); fv = 1'b0;
        finish_frame("t5");
        chk("t5 frame_num", 128'(frame_num), 128'(exp_frame));

        // reset mid-frame with fv held high
        frame_words.delete();
        for (int i = 0; i < 2; i++) frame_words.push_back(rand_valid());
        open_frame(); send_words(1'b0);
        rst = 1'b1;
        #1;
        chk("t6 rst q", q, 128'd0);
        chk("t6 rst qv", 128'(qv), 128'd0);
        chk("t6 rst frame_num", 128'(frame_num), 128'd0);
        chk("t6 rst corner_cnt", 128'(corner_cnt), 128'd0);
        chk("t6 rst drop_cnt", 128'(drop_cnt), 128'd0);
        chk("t6 rst overflow", 128'(overflow), 128'd0);
        got_q.delete(); exp_q.delete();
        exp_frame = 0;
        cyc();
        rst = 1'b0;
        repeat (10) cyc();
        chk("t6 no header qv", 128'(qv), 128'd0);
        chk("t6 no header frame_num", 128'(frame_num), 128'd0);
        fv = 1'b0; cyc();
        frame_words.delete();
        for (int i = 0; i < 4; i++) frame_words.push_back(rand_valid());
        model_frame();
        open_frame(); send_words(1'b0); fv = 1'b0;
        finish_frame("t6");

        // en low at fv rise -> frame ignored
        en = 1'b0;
        open_frame(); send_words(1'b0); fv = 1'b0;
        en = 1'b1;
        repeat (60) cyc();
        chk("t6 en0 beats", 128'(got_q.size()), 128'd0);
        chk("t6 en0 frame_num", 128'(frame_num), 128'(exp_frame));
        got_q.delete();

        // randomized frames with mixed valid/invalid words and gaps
        for (int f = 0; f < 6; f++) begin
            int n;
            n = int'($urandom_range(0, 14));
            frame_words.delete();
            for (int i = 0; i < n; i++)
                frame_words.push_back(($urandom_range(0, 1) == 1) ? rand_valid() : 32'($urandom));
            model_frame();
            open_frame(); send_words(1'b1); fv = 1'b0;
            finish_frame($sformatf("rand%0d", f));
            chk($sformatf("rand%0d corner_cnt", f), 128'(corner_cnt), 128'(m_corner));
            chk($sformatf("rand%0d drop_cnt", f), 128'(drop_cnt), 128'(m_drop));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
